branch_target_table: RTL and testbench

- Runtime-loadable, multi-bank successor to the fixed PC branch-target lookup.
- Holds BANKS independent tables of DEPTH branch targets, one bank per program (e.g. PROG_1, PROG_2).
- Tables are loaded serially over a valid/ready stream. The fetch stage selects the active bank and reads the target combinationally by index, as before.
- Sits between the decoder (supplies the branch index) and the PC register (consumes the target).

---
 rtl/btt_pkg.sv | 25 ++
 rtl/btt_load_fsm.sv | 77 +++++++
 rtl/branch_target_table.sv | 85 ++++++++
 tb/tb_branch_target_table.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btt_pkg.sv
// Shared types and constants for the multi-bank branch target table.
// Bank 0 powers up holding the original fixed PC lookup contents.
package btt_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam int TGT_W     = 12;
  localparam int NUM_BANKS = 2;
  localparam int BW        = $clog2(NUM_BANKS);
  localparam int DEF_N     = 8;

  localparam logic [TGT_W-1:0] DEFAULT_TABLE [DEF_N] = '{
    12'd13, 12'd20, 12'd2, 12'd7, 12'd7, 12'd117, 12'd59, 12'd132
  };

  // Reset value of one entry; only bank 0 carries non-zero defaults.
  function automatic logic [TGT_W-1:0] default_entry(input int bank, input int idx);
    logic [TGT_W-1:0] r;
    r = '0;
    for (int k = 0; k < DEF_N; k++)
      if (bank == 0 && k == idx) r = DEFAULT_TABLE[k];
    return r;
  endfunction

endpackage

// File: rtl/btt_load_fsm.sv
// Serial table loader: accepts a valid/ready beat stream and produces
// per-entry write strobes plus bank invalidate/validate events.
module btt_load_fsm
  import btt_pkg::*;
#(
  parameter  int DEPTH = 32,
  parameter  int BANKS = NUM_BANKS,
  localparam int PW    = $clog2(DEPTH),
  localparam int BSW   = $clog2(BANKS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld_start,
  input  logic [BSW-1:0] ld_bank,
  input  logic           ld_valid,
  input  logic           ld_last,
  output logic           ld_ready,
  output logic           ld_done,
  output logic           busy,
  output logic           start_acc,
  output logic           we,
  output logic [PW-1:0]  wr_ptr,
  output logic [BSW-1:0] wr_bank
);

  state_t state;

  assign start_acc = (state == IDLE) && ld_start;
  assign we        = ld_valid && ld_ready;

  // The final entry ends the load on its own so wr_ptr never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      wr_bank  <= '0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            state    <= LOAD;
            wr_bank  <= ld_bank;
            wr_ptr   <= '0;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (we) begin
            if (ld_last || wr_ptr == PW'(DEPTH - 1)) begin
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          ld_done <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
          ld_done  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/branch_target_table.sv
// Multi-bank branch target table: serially loadable banks, registered
// bank select and a zero-latency target read for the fetch stage.
module branch_target_table
  import btt_pkg::*;
#(
  parameter  int D     = TGT_W,
  parameter  int AW    = 5,
  parameter  int DEPTH = 32,
  parameter  int BANKS = NUM_BANKS,
  localparam int BSW   = $clog2(BANKS),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic [AW-1:0]  addr,
  output logic [D-1:0]   target,
  output logic           target_valid,
  input  logic [BSW-1:0] bank_sel,
  input  logic           bank_sel_we,
  output logic [BSW-1:0] active_bank,
  input  logic           ld_start,
  input  logic [BSW-1:0] ld_bank,
  input  logic           ld_valid,
  output logic           ld_ready,
  input  logic [D-1:0]   ld_data,
  input  logic           ld_last,
  output logic           ld_done,
  output logic           busy
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [D-1:0]     mem [BANKS][DEPTH];
  logic [BANKS-1:0] bank_valid;
  logic             start_acc;
  logic             we;
  logic [PW-1:0]    wr_ptr;
  logic [BSW-1:0]   wr_bank;

  btt_load_fsm #(.DEPTH(DEPTH), .BANKS(BANKS)) u_fsm (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .ld_start  (ld_start),
    .ld_bank   (ld_bank),
    .ld_valid  (ld_valid),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .busy      (busy),
    .start_acc (start_acc),
    .we        (we),
    .wr_ptr    (wr_ptr),
    .wr_bank   (wr_bank)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) active_bank <= '0;
    else if (bank_sel_we) active_bank <= bank_sel;
  end

  // A bank reads as invalid from load start until the cycle after DONE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bank_valid <= BANKS'(1);
    end else begin
      if (start_acc) bank_valid[ld_bank] <= 1'b0;
      if (ld_done)   bank_valid[wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < BANKS; b++)
        for (int i = 0; i < DEPTH; i++)
          mem[b][i] <= D'(default_entry(b, i));
    end else if (we) begin
      mem[wr_bank][wr_ptr] <= ld_data;
    end
  end

  // Invalid lookups return 0 so the PC register holds.
  assign target_valid = ({1'b0, addr} < DEPTH_L) && bank_valid[active_bank];
  assign target       = target_valid ? mem[active_bank][PW'(addr)] : '0;

endmodule

// File: tb/tb_branch_target_table.sv
// Scoreboard bench for branch_target_table: loads, bank switching,
// stalls, auto-termination and reset during a load.
module tb_branch_target_table;
  import btt_pkg::*;

  localparam int D     = 12;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int BANKS = 2;
  localparam int unsigned DEF [8] = '{13, 20, 2, 7, 7, 117, 59, 132};

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [AW-1:0] addr;
  logic [D-1:0]  target;
  logic          target_valid;
  logic [0:0]    bank_sel;
  logic          bank_sel_we;
  logic [0:0]    active_bank;
  logic          ld_start;
  logic [0:0]    ld_bank;
  logic          ld_valid;
  logic          ld_ready;
  logic [D-1:0]  ld_data;
  logic          ld_last;
  logic          ld_done;
  logic          busy;

  always #5 Clk = ~Clk;

  branch_target_table #(.D(D), .AW(AW), .DEPTH(DEPTH), .BANKS(BANKS)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .addr         (addr),
    .target       (target),
    .target_valid (target_valid),
    .bank_sel     (bank_sel),
    .bank_sel_we  (bank_sel_we),
    .active_bank  (active_bank),
    .ld_start     (ld_start),
    .ld_bank      (ld_bank),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_done      (ld_done),
    .busy         (busy)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t         sbq [$];
  logic [D-1:0] ldq [$];
  logic [D-1:0] mdl [BANKS][DEPTH];
  bit           mvld [BANKS];
  int           mact;
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t x;
    if (sbq.size() == 0) begin
      check("sb_empty", 32'(sbq.size()), 32'd1);
    end else begin
      x = sbq.pop_front();
      check(x.tag, got, x.exp);
    end
  endtask

  task automatic mdl_reset();
    for (int b = 0; b < BANKS; b++)
      for (int i = 0; i < DEPTH; i++) mdl[b][i] = '0;
    for (int i = 0; i < 8; i++) mdl[0][i] = D'(DEF[i]);
    mvld[0] = 1'b1;
    mvld[1] = 1'b0;
    mact    = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input string tag, input int a);
    logic [D-1:0] et;
    bit           ev;
    addr = AW'(a);
    ev   = (a < DEPTH) && mvld[mact];
    et   = ev ? mdl[mact][a] : '0;
    sb_push({tag, "_tgt"}, 32'(et));
    sb_push({tag, "_vld"}, 32'(ev));
    @(negedge Clk);
    sb_pop(32'(target));
    sb_pop(32'(target_valid));
  endtask

  task automatic sel(input int b);
    bank_sel    = 1'(b);
    bank_sel_we = 1'b1;
    tick();
    bank_sel_we = 1'b0;
    mact        = b;
  endtask

  // Streams ldq into a bank; stall_at inserts a 3-cycle ld_valid gap
  // (entered with bank 0 active), extra drives a beat after the last.
  task automatic do_load(input int bank, input bit use_last, input int stall_at, input bit extra);
    ld_bank  = 1'(bank);
    ld_start = 1'b1;
    tick();
    ld_start   = 1'b0;
    mvld[bank] = 1'b0;
    check("ready_in_load", 32'(ld_ready), 32'd1);
    check("busy_in_load", 32'(busy), 32'd1);
    for (int i = 0; i < ldq.size(); i++) begin
      if (i == stall_at) begin
        ld_valid = 1'b0;
        rd("stall_b0", 5);
        check("busy_stall", 32'(busy), 32'd1);
        sel(1);
        rd("stall_b1", 0);
        sel(0);
        tick();
      end
      ld_valid = 1'b1;
      ld_data  = ldq[i];
      ld_last  = use_last && (i == ldq.size() - 1);
      check($sformatf("beat%0d_ready", i), 32'(ld_ready), 32'd1);
      tick();
      mdl[bank][i] = ldq[i];
    end
    ld_valid = extra;
    ld_data  = 12'd999;
    ld_last  = 1'b0;
    sb_push("ld_done_pulse", 32'd1);
    sb_pop(32'(ld_done));
    check("ready_in_done", 32'(ld_ready), 32'd0);
    tick();
    ld_valid   = 1'b0;
    mvld[bank] = 1'b1;
    sb_push("ld_done_clear", 32'd0);
    sb_pop(32'(ld_done));
    check("busy_after", 32'(busy), 32'd0);
    check("ready_after", 32'(ld_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    Reset_n     = 1'b0;
    addr        = '0;
    bank_sel    = '0;
    bank_sel_we = 1'b0;
    ld_start    = 1'b0;
    ld_bank     = '0;
    ld_valid    = 1'b0;
    ld_data     = '0;
    ld_last     = 1'b0;
    mdl_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ready", 32'(ld_ready), 32'd0);
    check("rst_done", 32'(ld_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_active", 32'(active_bank), 32'd0);
    Reset_n = 1'b1;
    tick();

    for (int a = 0; a < 8; a++) rd($sformatf("def_a%0d", a), a);
    rd("def_a8", 8);
    rd("def_a31", 31);

    sel(1);
    check("active_b1", 32'(active_bank), 32'd1);
    rd("b1_invalid", 0);

    ldq = '{12'd16, 12'd408, 12'd693, 12'd720};
    do_load(1, 1'b1, -1, 1'b0);
    rd("short_a3", 3);
    rd("short_a4", 4);
    rd("short_a0", 0);

    ldq.delete();
    for (int i = 0; i < DEPTH; i++) ldq.push_back(D'((i * 53 + 11) & 12'hfff));
    do_load(1, 1'b0, -1, 1'b1);
    rd("full_a31", 31);
    rd("full_a0", 0);
    rd("full_a16", 16);

    sel(0);
    ldq = '{12'd100, 12'd107, 12'd114, 12'd121, 12'd128, 12'd135};
    do_load(1, 1'b1, 3, 1'b0);
    rd("after_stall_b0", 5);
    sel(1);
    for (int a = 0; a < DEPTH; a++) rd($sformatf("stall_chk_a%0d", a), a);

    sel(0);
    ld_bank  = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    mvld[0]  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = D'(i + 1);
      tick();
      mdl[0][i] = D'(i + 1);
    end
    ld_valid = 1'b0;
    rd("ld_b0_invalid", 5);
    #2;
    Reset_n = 1'b0;
    #1;
    mdl_reset();
    check("abort_ready", 32'(ld_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_active", 32'(active_bank), 32'd0);
    rd("abort_a5", 5);
    #2;
    Reset_n = 1'b1;
    tick();
    rd("post_a5", 5);
    rd("post_a0", 0);
    rd("post_a1", 1);
    sel(1);
    rd("post_b1", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
